arithmetic_unit: RTL and testbench

ARITHMETIC_UNIT -- requirements
Module: arithmetic_unit

---
 rtl/arithmetic_unit_full_adder.sv | 15 +
 rtl/arithmetic_unit.sv | 82 ++++++++
 tb/tb_arithmetic_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/arithmetic_unit_full_adder.sv
// One-bit full adder: the repeated cell of the ripple-carry chain in
// arithmetic_unit. Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is the three-way parity; carry is the majority of the three inputs.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/arithmetic_unit.sv
// Registered SIZE-bit add/subtract unit.
// A combinational ripple-carry chain computes {carry, sum} of operandA and
// either operandB (add) or ~operandB + 1 (subtract). The result is captured
// on every rising clock edge, so outputs show the operation whose inputs
// were present at the previous edge. In subtraction carryOut=1 means no
// borrow (operandA >= operandB, unsigned).
module arithmetic_unit #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] operandA,
  input  logic [SIZE-1:0] operandB,
  input  logic            control,
  output logic [SIZE-1:0] result,
  output logic            carryOut
);

  // Encoding of the control input.
  localparam logic CTRL_ADD = 1'b0;
  localparam logic CTRL_SUB = 1'b1;

  logic            sub_en;
  logic [SIZE-1:0] b_eff;
  logic [SIZE:0]   carry;
  logic [SIZE-1:0] sum;

  logic [SIZE-1:0] result_d, result_q;
  logic            carry_out_d, carry_out_q;

  // Decode the operation select into the subtract enable.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    sub_en = 1'b0;
    case (control)
      CTRL_ADD: sub_en = 1'b0;
      CTRL_SUB: sub_en = 1'b1;
      default:  sub_en = 1'b0;
    endcase
  end

  // Subtraction is A + ~B + 1: each B bit is XORed with the subtract enable
  // ahead of the chain, and the same enable is the chain's carry-in.
  assign b_eff    = operandB ^ {SIZE{sub_en}};
  assign carry[0] = sub_en;

  // Ripple-carry chain, LSB first; carry[SIZE] is the carry out of the MSB.
  for (genvar i = 0; i < SIZE; i++) begin : g_chain
    full_adder u_fa (
      .a    (operandA[i]),
      .b    (b_eff[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Next-state of the output register is the chain output, unconditionally:
  // there is no handshake, every edge captures a new operation.
  always_comb begin
    result_d    = sum;
    carry_out_d = carry[SIZE];
  end

  // Output register with asynchronous clear; reset drops any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement or block order.
    if (!rst_n) begin
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
    end
  end

  assign result   = result_q;
  assign carryOut = carry_out_q;

endmodule : arithmetic_unit

// File: tb/tb_arithmetic_unit.sv
// Self-checking bench for arithmetic_unit (SIZE=4): directed vectors,
// reset behaviour, input isolation between edges, exhaustive sweep of all
// operand pairs in both modes and a randomized back-to-back stream, all
// compared against a plain-arithmetic reference model.
module tb_arithmetic_unit;

  localparam int SIZE = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [SIZE-1:0] operandA;
  logic [SIZE-1:0] operandB;
  logic            control;
  logic [SIZE-1:0] result;
  logic            carryOut;

  int vectors    = 0;
  int miscompares = 0;

  arithmetic_unit #(.SIZE(SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .operandA (operandA),
    .operandB (operandB),
    .control  (control),
    .result   (result),
    .carryOut (carryOut)
  );

  always #5 clk = ~clk;

  // Reference: add is the plain integer sum; subtract gives the difference
  // mod 2^SIZE with carry meaning "no borrow" (A >= B).
  function automatic logic [SIZE:0] model(input logic [SIZE-1:0] a,
                                          input logic [SIZE-1:0] b,
                                          input logic c);
    int unsigned ai = a;
    int unsigned bi = b;
    if (!c) return (SIZE+1)'(ai + bi);
    return {(ai >= bi), SIZE'(ai - bi)};
  endfunction

  // Drive one operation away from the edge, then check one cycle later.
  task automatic apply(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                       input logic c, input logic [SIZE:0] exp,
                       input string name);
    @(negedge clk);
    operandA = a;
    operandB = b;
    control  = c;
    @(posedge clk);
    #1;
    vectors++;
    if ({carryOut, result} !== exp) begin
      miscompares++;
      $display("FAIL %s: A=%b B=%b ctl=%b got carry=%b result=%b want carry=%b result=%b",
               name, a, b, c, carryOut, result, exp[SIZE], exp[SIZE-1:0]);
    end
  endtask

  task automatic test_reset;
    rst_n    = 1'b1;
    operandA = 4'b0101;
    operandB = 4'b0011;
    control  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (result !== 4'b0000 || carryOut !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got carry=%b result=%b want carry=0 result=0000",
               carryOut, result);
    end
    // Hold reset across an edge: outputs must stay cleared.
    @(posedge clk);
    #1;
    vectors++;
    if (result !== 4'b0000 || carryOut !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got carry=%b result=%b want carry=0 result=0000",
               carryOut, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    apply(4'b0101, 4'b0011, 1'b0, 5'b0_1000, "add_5_3");
    apply(4'b0101, 4'b0011, 1'b1, 5'b1_0010, "sub_5_3");
    apply(4'b1111, 4'b0001, 1'b0, 5'b1_0000, "add_wrap");
    apply(4'b1000, 4'b0001, 1'b1, 5'b1_0111, "sub_8_1");
    apply(4'b0000, 4'b0000, 1'b0, 5'b0_0000, "add_zero");
    apply(4'b0011, 4'b0011, 1'b1, 5'b1_0000, "sub_equal");
    apply(4'b0001, 4'b0010, 1'b1, 5'b0_1111, "sub_borrow");
  endtask

  // Inputs changed between edges must not disturb the registered outputs.
  task automatic test_input_isolation;
    apply(4'b0110, 4'b0111, 1'b0, 5'b0_1101, "iso_setup");
    operandA = 4'b1111;
    operandB = 4'b1111;
    control  = 1'b1;
    #2;
    vectors++;
    if (result !== 4'b1101 || carryOut !== 1'b0) begin
      miscompares++;
      $display("FAIL input_isolation: got carry=%b result=%b want carry=0 result=1101",
               carryOut, result);
    end
  endtask

  // Reset between edges clears at once; the pending op is not replayed.
  task automatic test_mid_reset;
    apply(4'b0101, 4'b0011, 1'b0, 5'b0_1000, "midrst_setup");
    @(negedge clk);
    operandA = 4'b0001;
    operandB = 4'b0001;
    control  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (result !== 4'b0000 || carryOut !== 1'b0) begin
      miscompares++;
      $display("FAIL async_clear: got carry=%b result=%b want carry=0 result=0000",
               carryOut, result);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (result !== 4'b0000 || carryOut !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_discard: got carry=%b result=%b want carry=0 result=0000",
               carryOut, result);
    end
    // Release with new inputs already present; first edge captures them.
    @(negedge clk);
    operandA = 4'b0010;
    operandB = 4'b0100;
    control  = 1'b1;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (result !== 4'b1110 || carryOut !== 1'b0) begin
      miscompares++;
      $display("FAIL first_after_release: got carry=%b result=%b want carry=0 result=1110",
               carryOut, result);
    end
  endtask

  // Every operand pair in both modes, one per cycle, back to back.
  task automatic test_exhaustive;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 256; p++) begin
        logic [SIZE-1:0] a = SIZE'(p >> 4);
        logic [SIZE-1:0] b = SIZE'(p);
        apply(a, b, c[0], model(a, b, c[0]), "exhaustive");
      end
    end
  endtask

  // Random back-to-back stream with control toggling freely.
  task automatic test_back_to_back;
    for (int i = 0; i < 200; i++) begin
      logic [SIZE-1:0] a = SIZE'($urandom);
      logic [SIZE-1:0] b = SIZE'($urandom);
      logic            c = 1'($urandom);
      apply(a, b, c, model(a, b, c), "random_b2b");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_input_isolation();
    test_mid_reset();
    test_exhaustive();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_arithmetic_unit
